// File: rtl/bist_pkg.sv
// Shared types and default sizing for the BIST fail logger and its record FIFO.
package bist_pkg;

  localparam int SIZE   = 6;
  localparam int LENGTH = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } logger_state_t;

  typedef struct packed {
    logic [SIZE-1:0]   addr;
    logic [LENGTH-1:0] exp;
    logic [LENGTH-1:0] act;
  } fail_rec_t;

endpackage

// File: rtl/bist_fail_fifo.sv
// First-word-fall-through FIFO of fail records; dout shows the head entry
// straight from registered storage, so a push into an empty FIFO is visible after that edge.
module bist_fail_fifo
  import bist_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      push,
  input  fail_rec_t din,
  input  logic      pop,
  output fail_rec_t dout,
  output logic      empty,
  output logic      full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fail_rec_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == FULL_CNT);
  assign dout  = r_mem[r_rd_ptr];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bist_fail_logger.sv
// Logs BIST compare fails into a small record FIFO and keeps a saturating fail
// count, a sticky overflow flag and the run-level done/pass verdict.
module bist_fail_logger #(
  parameter int SIZE   = bist_pkg::SIZE,
  parameter int LENGTH = bist_pkg::LENGTH,
  parameter int DEPTH  = bist_pkg::DEPTH,
  parameter int CNT_W  = bist_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              test_active,
  input  logic              fail,
  input  logic [SIZE-1:0]   fail_addr,
  input  logic [LENGTH-1:0] fail_exp,
  input  logic [LENGTH-1:0] fail_act,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [SIZE-1:0]   rec_addr,
  output logic [LENGTH-1:0] rec_exp,
  output logic [LENGTH-1:0] rec_act,
  output logic [CNT_W-1:0]  fail_count,
  output logic              overflow,
  output logic              done,
  output logic              pass
);

  import bist_pkg::*;

  logger_state_t    r_state;
  logic [CNT_W-1:0] r_fail_count;
  logic             r_overflow;
  logic             r_done;
  logic             r_pass;

  fail_rec_t w_din;
  fail_rec_t w_head;
  logic      w_empty;
  logic      w_full;
  logic      w_pop;
  logic      w_capture;
  logic      w_push;
  logic      w_drop;

  assign w_din.addr = fail_addr;
  assign w_din.exp  = fail_exp;
  assign w_din.act  = fail_act;

  // start wins over capture, so a fail on the start cycle is never logged.
  assign w_capture = (r_state == RUN) && test_active && fail && !start;
  assign w_pop     = !w_empty && rec_ready;
  assign w_push    = w_capture && (!w_full || w_pop);
  assign w_drop    = w_capture && w_full && !w_pop;

  bist_fail_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_pop),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_fail_count <= '0;
      r_overflow   <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else if (start) begin
      r_state      <= ARMED;
      r_fail_count <= '0;
      r_overflow   <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      if (w_capture && (r_fail_count != '1)) begin
        r_fail_count <= r_fail_count + CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        IDLE: r_state <= IDLE;
        ARMED: begin
          if (test_active) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          // No capture on the exit cycle, so the count here is final.
          if (!test_active) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_pass  <= (r_fail_count == '0);
          end
        end
        DONE: r_state <= DONE;
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign rec_valid  = !w_empty;
  assign rec_addr   = w_empty ? '0 : w_head.addr;
  assign rec_exp    = w_empty ? '0 : w_head.exp;
  assign rec_act    = w_empty ? '0 : w_head.act;
  assign fail_count = r_fail_count;
  assign overflow   = r_overflow;
  assign done       = r_done;
  assign pass       = r_pass;

endmodule

// File: tb/tb_bist_fail_logger.sv
// Directed bench for bist_fail_logger: reset, clean run, single fail, overflow,
// full FIFO with simultaneous pop/push, counter saturation and mid-run restart.
module tb_bist_fail_logger;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       test_active;
  logic       fail;
  logic [5:0] fail_addr;
  logic [7:0] fail_exp;
  logic [7:0] fail_act;
  logic       rec_valid;
  logic       rec_ready;
  logic [5:0] rec_addr;
  logic [7:0] rec_exp;
  logic [7:0] rec_act;
  logic [7:0] fail_count;
  logic       overflow;
  logic       done;
  logic       pass;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bist_fail_logger dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .test_active (test_active),
    .fail        (fail),
    .fail_addr   (fail_addr),
    .fail_exp    (fail_exp),
    .fail_act    (fail_act),
    .rec_valid   (rec_valid),
    .rec_ready   (rec_ready),
    .rec_addr    (rec_addr),
    .rec_exp     (rec_exp),
    .rec_act     (rec_act),
    .fail_count  (fail_count),
    .overflow    (overflow),
    .done        (done),
    .pass        (pass)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then raise test_active so the logger is in RUN on return.
  task automatic run_arm();
    start = 1'b1;
    tick();
    start = 1'b0;
    test_active = 1'b1;
    tick();
  endtask

  task automatic fail_pulse(input logic [5:0] a, input logic [7:0] e, input logic [7:0] x);
    fail = 1'b1;
    fail_addr = a;
    fail_exp = e;
    fail_act = x;
    tick();
    fail = 1'b0;
  endtask

  task automatic pop_one();
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
  endtask

  int n;
  logic [5:0] last_addr;
  logic [5:0] exp_order [4];

  initial begin
    rst = 1'b1; start = 1'b0; test_active = 1'b0; fail = 1'b0;
    fail_addr = 6'h00; fail_exp = 8'h00; fail_act = 8'h00; rec_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(rec_valid), 32'd0);
    chk("rst_addr", 32'(rec_addr), 32'd0);
    chk("rst_exp", 32'(rec_exp), 32'd0);
    chk("rst_act", 32'(rec_act), 32'd0);
    chk("rst_count", 32'(fail_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);

    // Clean run: 128 active cycles without fails.
    start = 1'b1;
    tick();
    start = 1'b0;
    test_active = 1'b1;
    repeat (128) tick();
    chk("clean_done_early", 32'(done), 32'd0);
    test_active = 1'b0;
    tick();
    chk("clean_done", 32'(done), 32'd1);
    chk("clean_pass", 32'(pass), 32'd1);
    chk("clean_count", 32'(fail_count), 32'd0);
    chk("clean_valid", 32'(rec_valid), 32'd0);

    // Single fail, then a fail on the exit cycle that must be ignored.
    run_arm();
    chk("single_pass_cleared", 32'(pass), 32'd0);
    fail_pulse(6'h15, 8'hAA, 8'hAB);
    chk("single_valid", 32'(rec_valid), 32'd1);
    chk("single_addr", 32'(rec_addr), 32'h15);
    chk("single_exp", 32'(rec_exp), 32'hAA);
    chk("single_act", 32'(rec_act), 32'hAB);
    chk("single_count", 32'(fail_count), 32'd1);
    tick();
    chk("single_hold_addr", 32'(rec_addr), 32'h15);
    test_active = 1'b0;
    fail_pulse(6'h22, 8'h11, 8'h12);
    chk("exit_count", 32'(fail_count), 32'd1);
    chk("single_done", 32'(done), 32'd1);
    chk("single_pass", 32'(pass), 32'd0);
    pop_one();
    chk("single_popped", 32'(rec_valid), 32'd0);

    // Overflow: six fails into a four-entry FIFO.
    run_arm();
    for (int i = 0; i < 6; i++) fail_pulse(6'(i), 8'(8'h10 + i), 8'(8'h20 + i));
    chk("ovf_count", 32'(fail_count), 32'd6);
    chk("ovf_flag", 32'(overflow), 32'd1);
    test_active = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_valid", 32'(rec_valid), 32'd1);
      chk("ovf_drain_addr", 32'(rec_addr), 32'(i));
      chk("ovf_drain_act", 32'(rec_act), 32'(8'h20 + i));
      pop_one();
    end
    chk("ovf_drain_empty", 32'(rec_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with simultaneous pop and push.
    run_arm();
    chk("restart_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) fail_pulse(6'(6'h30 + i), 8'h55, 8'h54);
    fail = 1'b1; fail_addr = 6'h3F; fail_exp = 8'h0F; fail_act = 8'h0E;
    rec_ready = 1'b1;
    tick();
    fail = 1'b0; rec_ready = 1'b0;
    chk("fullpp_ovf", 32'(overflow), 32'd0);
    chk("fullpp_count", 32'(fail_count), 32'd5);
    test_active = 1'b0;
    tick();
    exp_order[0] = 6'h31; exp_order[1] = 6'h32; exp_order[2] = 6'h33; exp_order[3] = 6'h3F;
    n = 0;
    last_addr = 6'h00;
    while (rec_valid && n < 10) begin
      if (n < 4) chk("fullpp_order", 32'(rec_addr), 32'(exp_order[n]));
      last_addr = rec_addr;
      pop_one();
      n++;
    end
    chk("fullpp_occupancy", 32'(n), 32'd4);
    chk("fullpp_last", 32'(last_addr), 32'h3F);

    // Saturation, then restart mid-run into ARMED.
    run_arm();
    fail = 1'b1; fail_addr = 6'h01; fail_exp = 8'h00; fail_act = 8'hFF;
    repeat (300) tick();
    fail = 1'b0;
    chk("sat_count", 32'(fail_count), 32'd255);
    chk("sat_ovf", 32'(overflow), 32'd1);
    start = 1'b1;
    test_active = 1'b0;
    tick();
    start = 1'b0;
    chk("restart_count", 32'(fail_count), 32'd0);
    chk("restart_ovf", 32'(overflow), 32'd0);
    chk("restart_valid", 32'(rec_valid), 32'd0);
    chk("restart_done", 32'(done), 32'd0);
    fail = 1'b1;
    repeat (3) tick();
    fail = 1'b0;
    chk("armed_ignore_count", 32'(fail_count), 32'd0);
    chk("armed_ignore_valid", 32'(rec_valid), 32'd0);
    test_active = 1'b1;
    tick();
    fail_pulse(6'h2A, 8'h5A, 8'h5B);
    chk("armed_then_run", 32'(fail_count), 32'd1);
    chk("armed_then_run_addr", 32'(rec_addr), 32'h2A);

    // Reset mid-run discards everything.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(rec_valid), 32'd0);
    chk("midrst_count", 32'(fail_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bist_fail_logger.md
Name: bist_fail_logger

Overview:
- Diagnosis stage directly downstream of the bist block; consumes its per-cycle fail pulse with the failing address, expected pattern and RAM read data.
- Buffers failing records in a small FIFO for later readout over a valid/ready port.
- Keeps a saturating fail count, a sticky overflow flag, and a run-level pass/done verdict.

Parameters:
- SIZE, 6, address width (matches bist SIZE)
- LENGTH, 8, data width (matches bist LENGTH)
- DEPTH, 4, record FIFO entries; power of 2, at least 2
- CNT_W, 8, fail counter width

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous to clk, active-high
- start  input  1  one-cycle pulse; clears log, arms logger
- test_active  input  1  BIST mode indicator (bist NbarT)
- fail  input  1  compare-fail strobe from bist
- fail_addr  input  SIZE  RAM address of the failing read
- fail_exp  input  LENGTH  expected pattern (decoder output)
- fail_act  input  LENGTH  RAM read data (bist dataout)
- rec_valid  output  1  FIFO head record available
- rec_ready  input  1  consumer accepts head record
- rec_addr  output  SIZE  head record address
- rec_exp  output  LENGTH  head record expected data
- rec_act  output  LENGTH  head record actual data
- fail_count  output  CNT_W  total fails seen this run; saturating
- overflow  output  1  sticky: at least one fail was dropped
- done  output  1  run finished
- pass  output  1  run finished with zero fails

Behaviour:
- Reset: state IDLE; FIFO empty; rec_valid=0; rec_* = 0; fail_count=0; overflow=0; done=0; pass=0.
- FSM states: IDLE, ARMED, RUN, DONE.
  - IDLE -> ARMED on start.
  - ARMED -> RUN on the first cycle with test_active=1.
  - RUN -> DONE on the first cycle with test_active=0.
  - DONE holds until start or rst.
- start in any state: clear FIFO, fail_count, overflow, done and pass, then go to ARMED. start has priority over every other event in that cycle.
- Capture happens only in RUN with test_active=1 and fail=1. fail is ignored in IDLE, ARMED and DONE, and on the cycle the FSM leaves RUN.
- Per captured fail: fail_count increments, saturating at 2^CNT_W-1. A record {fail_addr, fail_exp, fail_act} is pushed if there is space.
- Latency: a record pushed on edge N appears on rec_* with rec_valid=1 after edge N if the FIFO was empty (FWFT, registered storage).
- Readout: pop occurs when rec_valid and rec_ready are both 1. rec_* stay stable while rec_valid=1 and rec_ready=0. Readout is allowed in every state.
- Full FIFO:
  - Push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle (occupancy unchanged).
  - A fail arriving while full with no pop is dropped and sets overflow=1; overflow stays set until start or rst.
  - A dropped fail still increments fail_count.
- Empty FIFO with push and pop in the same cycle: pop is not possible (rec_valid=0), so only the push takes effect.
- Pointers: log2(DEPTH) bits wrapping modulo DEPTH, plus an occupancy counter of log2(DEPTH)+1 bits.
- DONE outputs:
  - done=1 registered on entry to DONE.
  - pass = done && fail_count==0, valid while in DONE; 0 in all other states.
- rst mid-run: everything returns to reset values on the next edge; buffered records are lost.

Decomposition:
- Package bist_pkg holds:
  - typedef logger_state_t (enum IDLE, ARMED, RUN, DONE)
  - typedef fail_rec_t (packed struct: addr[SIZE], exp[LENGTH], act[LENGTH])
  - default constants SIZE, LENGTH, DEPTH, CNT_W
- Sub-module bist_fail_fifo:
  - synchronous FWFT FIFO of fail_rec_t
  - ports: clk, rst, clr, push, din, pop, dout, empty, full
  - the logger instantiates one of these.

Test Plan:
- (Defaults SIZE=6, LENGTH=8, DEPTH=4, CNT_W=8.)
- Reset and clean run: assert rst for 2 cycles, then check all outputs are 0. Pulse start, hold test_active=1 for 128 cycles with fail=0, then drop it. Required: done=1, pass=1, fail_count=0, rec_valid=0.
- Single fail: in RUN, fail=1 with addr 0x15, exp 0xAA, act 0xAB for one cycle, rec_ready=0. Required: next cycle rec_valid=1 with rec_addr=0x15, rec_exp=0xAA, rec_act=0xAB; fail_count=1. After the run ends, pass=0 and done=1. Raise rec_ready and check rec_valid=0 one cycle later.
- Overflow: 6 consecutive fails at addrs 0x00..0x05 with rec_ready=0. Required: fail_count=6 and overflow=1. Draining yields exactly 0x00..0x03 in order.
- Full with simultaneous pop and push: fill 4 entries, then in one cycle assert fail (addr 0x3F) and rec_ready=1. Required: overflow stays 0, occupancy stays 4, and the last record drained is 0x3F.
- Saturation and restart: 300 fails in RUN. Required: fail_count=255. Then pulse start mid-run. Required: fail_count=0, overflow=0, FIFO empty, state ARMED; fail pulses in ARMED leave fail_count at 0.
